pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard, flush and data-memory stall controller for a 5-stage in-order pipeline.
// Produces stage enables/flushes combinationally; tracks memory waits, timeout error and perf counters.
module pipeline_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  IFID_rs1,
    input  logic [4:0]  IFID_rs2,
    input  logic        IFID_use_rs1,
    input  logic        IFID_use_rs2,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_rd,
    input  logic        branch_taken,
    input  logic        EXMEM_MemRead,
    input  logic        EXMEM_MemWrite,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        IFID_en,
    output logic        IDEX_en,
    output logic        EXMEM_en,
    output logic        MEMWB_en,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [1:0]  state
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERR      = 2'd2;

    // The wait counter starts at 0 in the first MEM_WAIT cycle, so TIMEOUT stalled cycles end at TIMEOUT-2.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 2);

    logic [1:0]  state_reg, state_next;
    logic [7:0]  wait_reg, wait_next;
    logic        err_reg;
    logic [31:0] stall_reg, flush_reg;
    logic        mem_act, freeze, hazard, stall_evt, flush_evt;

    always_comb begin
        mem_act = EXMEM_MemRead | EXMEM_MemWrite;
        hazard  = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                  ((IFID_use_rs1 && (IFID_rs1 == IDEX_rd)) ||
                   (IFID_use_rs2 && (IFID_rs2 == IDEX_rd)));
        dmem_req = rstn && (state_reg != ERR) && mem_act;
        freeze   = dmem_req && !dmem_ready;

        pc_en      = 1'b1;
        IFID_en    = 1'b1;
        IDEX_en    = 1'b1;
        EXMEM_en   = 1'b1;
        MEMWB_en   = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;

        if (!rstn) begin
            // stage registers run their own reset; leave them enabled
        end else if (state_reg == ERR) begin
            pc_en    = 1'b0;
            IFID_en  = 1'b0;
            IDEX_en  = 1'b0;
            EXMEM_en = 1'b0;
            MEMWB_en = 1'b0;
        end else if (freeze) begin
            pc_en     = 1'b0;
            IFID_en   = 1'b0;
            IDEX_en   = 1'b0;
            EXMEM_en  = 1'b0;
            MEMWB_en  = 1'b0;
            stall_evt = 1'b1;
        end else if (branch_taken) begin
            // the instruction in ID is wrong-path, so any load-use hazard on it is moot
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (hazard) begin
            pc_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
            stall_evt  = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        case (state_reg)
            RUN: begin
                if (freeze) begin
                    state_next = MEM_WAIT;
                    wait_next  = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (!mem_act || dmem_ready) begin
                    state_next = RUN;
                end else if (wait_reg >= WAIT_LIMIT) begin
                    state_next = ERR;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            default: begin
                state_next = state_reg;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= RUN;
            wait_reg  <= 8'd0;
            err_reg   <= 1'b0;
            stall_reg <= 32'd0;
            flush_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            err_reg   <= err_reg | (state_next == ERR);
            if (stall_evt && (stall_reg != 32'hFFFF_FFFF)) begin
                stall_reg <= stall_reg + 32'd1;
            end
            if (flush_evt && (flush_reg != 32'hFFFF_FFFF)) begin
                flush_reg <= flush_reg + 32'd1;
            end
        end
    end

    assign state     = state_reg;
    assign mem_err   = err_reg;
    assign stall_cnt = stall_reg;
    assign flush_cnt = flush_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a behavioural model pushes expected outputs per cycle,
// which are popped and compared against the DUT mid-cycle (combinational) and after the edge (registers).
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  IFID_rs1, IFID_rs2, IDEX_rd;
    logic        IFID_use_rs1, IFID_use_rs2, IDEX_MemRead, branch_taken;
    logic        EXMEM_MemRead, EXMEM_MemWrite, dmem_ready;
    logic        dmem_req, pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
    logic        IFID_flush, IDEX_flush, mem_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  state;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
        .branch_taken(branch_taken),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_en(pc_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en),
        .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  comb;   // {pc,ifid,idex,exmem,memwb enables, ifid_flush, idex_flush, dmem_req}
        logic [1:0]  st;
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state
    logic [1:0]  m_state = 2'd0;
    int          m_stalled = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_sc = 32'd0;
    logic [31:0] m_fc = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic idle();
        rstn = 1'b1;
        IFID_rs1 = 5'd1; IFID_rs2 = 5'd2; IFID_use_rs1 = 1'b0; IFID_use_rs2 = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_rd = 5'd0; branch_taken = 1'b0;
        EXMEM_MemRead = 1'b0; EXMEM_MemWrite = 1'b0; dmem_ready = 1'b1;
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_push();
        exp_t e;
        logic act, frz, hz;
        act = EXMEM_MemRead | EXMEM_MemWrite;
        hz  = IDEX_MemRead && IDEX_rd != 0 &&
              ((IFID_use_rs1 && IFID_rs1 == IDEX_rd) || (IFID_use_rs2 && IFID_rs2 == IDEX_rd));
        if (!rstn) begin
            e.comb = 8'b11111_00_0;
            m_state = 2'd0; m_err = 1'b0; m_sc = 0; m_fc = 0; m_stalled = 0;
        end else if (m_state == 2'd2) begin
            e.comb = 8'b00000_00_0;
        end else begin
            frz = act && !dmem_ready;
            if (frz)               e.comb = 8'b00000_00_1;
            else if (branch_taken) e.comb = {5'b11111, 2'b11, act};
            else if (hz)           e.comb = {5'b00111, 2'b01, act};
            else                   e.comb = {5'b11111, 2'b00, act};
            if (frz || (!branch_taken && hz)) m_sc = sat_inc(m_sc);
            if (!frz && branch_taken)         m_fc = sat_inc(m_fc);
            if (m_state == 2'd0) begin
                if (frz) begin
                    m_state = 2'd1;
                    m_stalled = 1;
                end
            end else if (!act || dmem_ready) begin
                m_state = 2'd0;
            end else begin
                m_stalled++;
                if (m_stalled == TIMEOUT) begin
                    m_state = 2'd2;
                    m_err = 1'b1;
                end
            end
        end
        e.st = m_state; e.err = m_err; e.sc = m_sc; e.fc = m_fc;
        sb.push_back(e);
    endtask

    // one transaction: drive at negedge, compare combinational outputs, then registers after the edge
    task automatic step();
        exp_t e;
        model_push();
        #2;
        e = sb.pop_front();
        check("comb_outputs", {24'd0, pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
                               IFID_flush, IDEX_flush, dmem_req}, {24'd0, e.comb});
        @(posedge clk);
        #1;
        check("state", {30'd0, state}, {30'd0, e.st});
        check("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        check("stall_cnt", stall_cnt, e.sc);
        check("flush_cnt", flush_cnt, e.fc);
        $display("cyc %0d rstn=%0b comb=%b state=%0d err=%0b stall=%0d flush=%0d",
                 cyc, rstn, e.comb, state, mem_err, stall_cnt, flush_cnt);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] regs [4];
        regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd7;
        idle();
        rstn = 1'b0;
        @(negedge clk);
        step();
        step();
        rstn = 1'b1;
        step();

        // load-use hazard on rs1
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; IFID_rs1 = 5'd5; IFID_use_rs1 = 1'b1;
        step();
        check("req032_stall_one", stall_cnt, 32'd1);
        idle(); step();
        // rd = x0 and unused source: no stall
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd0; IFID_rs1 = 5'd0; IFID_use_rs1 = 1'b1; step();
        IDEX_rd = 5'd5; IFID_rs1 = 5'd5; IFID_use_rs1 = 1'b0; step();
        // hazard via rs2
        IFID_rs2 = 5'd5; IFID_use_rs2 = 1'b1; step();
        // branch together with hazard
        branch_taken = 1'b1; step();
        idle(); step();

        // memory read waits 3 cycles then completes
        EXMEM_MemRead = 1'b1; dmem_ready = 1'b0;
        repeat (3) step();
        dmem_ready = 1'b1; step();
        idle(); step();

        // mem_act drops during wait
        EXMEM_MemWrite = 1'b1; dmem_ready = 1'b0;
        repeat (2) step();
        EXMEM_MemWrite = 1'b0; step();
        idle(); step();

        // timeout into ERR, hazard and branch ignored there, then reset
        EXMEM_MemRead = 1'b1; dmem_ready = 1'b0;
        repeat (TIMEOUT) step();
        check("req036_err_state", {30'd0, state}, 32'd2);
        branch_taken = 1'b1; step();
        idle(); rstn = 1'b0; step();
        check("req036_reset_cnt", stall_cnt, 32'd0);
        idle(); step();

        // randomized traffic with periodic reset
        for (int i = 0; i < 240; i++) begin
            idle();
            rstn          = (i % 60 != 59);
            IFID_rs1      = regs[$urandom_range(0, 3)];
            IFID_rs2      = regs[$urandom_range(0, 3)];
            IDEX_rd       = regs[$urandom_range(0, 3)];
            IFID_use_rs1  = 1'($urandom_range(0, 1));
            IFID_use_rs2  = 1'($urandom_range(0, 1));
            IDEX_MemRead  = 1'($urandom_range(0, 1));
            branch_taken  = ($urandom_range(0, 5) == 0);
            EXMEM_MemRead = ($urandom_range(0, 2) == 0);
            EXMEM_MemWrite = ($urandom_range(0, 3) == 0);
            dmem_ready    = ($urandom_range(0, 3) != 0);
            step();
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
